// File: rtl/weight_bit_serializer.sv
// Bit-serial weight feeder: one {sign, Q5.10 magnitude} word per FRAME_LEN-cycle frame, magnitude MSB first.
// Optional build macro WSER_FRAME_COUNT_EN adds a 16-bit count of result_valid pulses on port frame_count.
module weight_bit_serializer #(
    parameter int WORD_W    = 16,
    parameter int FRAME_LEN = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              enable_out,
    output logic              weight_bit,
    output logic              busy,
`ifdef WSER_FRAME_COUNT_EN
    output logic [15:0]       frame_count,
`endif
    output logic              result_valid
);

    localparam int PH_W = $clog2(FRAME_LEN);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(FRAME_LEN - 1);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_r, state_s;
    logic [PH_W-1:0]   phase_r, phase_s;
    logic [WORD_W-1:0] buf_r, buf_s;
    logic              buf_full_r, buf_full_s;
    logic [WORD_W-1:0] shift_r, shift_s;
    logic [1:0]        rv_pipe_r, rv_pipe_s;
    logic              enable_r, weight_bit_r, in_ready_r, busy_r;
    logic              weight_bit_s;
    logic              load_s, accept_s, frame_end_s;

    // Next-state decode for the frame FSM, holding buffer and serial shifter
    always_comb begin
        state_s      = state_r;
        phase_s      = {PH_W{1'b0}};
        buf_s        = buf_r;
        buf_full_s   = buf_full_r;
        shift_s      = shift_r;
        weight_bit_s = 1'b0;
        frame_end_s  = (state_r == ST_RUN) && (phase_r == PH_LAST);
        accept_s     = in_valid && in_ready_r;
        load_s       = buf_full_r && ((state_r == ST_IDLE) || frame_end_s);

        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (frame_end_s && !buf_full_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        if ((state_r == ST_RUN) && !frame_end_s) begin
            phase_s = phase_r + PH_W'(1);
        end else begin
            phase_s = {PH_W{1'b0}};
        end

        // Shifter holds {magnitude, sign} so the sign falls out right after the magnitude LSB
        if (load_s) begin
            shift_s = {buf_r[WORD_W-2:0], buf_r[WORD_W-1]};
        end else if (state_r == ST_RUN) begin
            shift_s = {shift_r[WORD_W-2:0], 1'b0};
        end else begin
            shift_s = shift_r;
        end

        if ((state_r == ST_RUN) && !frame_end_s) begin
            weight_bit_s = shift_r[WORD_W-1];
        end else begin
            weight_bit_s = 1'b0;
        end

        if (load_s) begin
            buf_full_s = 1'b0;
        end else if (accept_s) begin
            buf_full_s = 1'b1;
            buf_s      = in_data;
        end else begin
            buf_full_s = buf_full_r;
        end

        rv_pipe_s = {rv_pipe_r[0], frame_end_s};
    end

    // State and registered outputs; reset abandons any in-flight frame and its result pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            phase_r      <= {PH_W{1'b0}};
            buf_r        <= {WORD_W{1'b0}};
            buf_full_r   <= 1'b0;
            shift_r      <= {WORD_W{1'b0}};
            rv_pipe_r    <= 2'b00;
            enable_r     <= 1'b0;
            weight_bit_r <= 1'b0;
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            phase_r      <= phase_s;
            buf_r        <= buf_s;
            buf_full_r   <= buf_full_s;
            shift_r      <= shift_s;
            rv_pipe_r    <= rv_pipe_s;
            enable_r     <= (state_s == ST_RUN);
            weight_bit_r <= weight_bit_s;
            in_ready_r   <= !buf_full_s;
            busy_r       <= (state_s == ST_RUN) || buf_full_s;
        end
    end

    assign enable_out   = enable_r;
    assign weight_bit   = weight_bit_r;
    assign in_ready     = in_ready_r;
    assign busy         = busy_r;
    assign result_valid = rv_pipe_r[1];

`ifdef WSER_FRAME_COUNT_EN
    logic [15:0] frame_count_r;

    // Counts product-valid pulses, wrapping naturally at 16 bits
    always_ff @(posedge clk) begin
        if (!reset) begin
            frame_count_r <= 16'h0000;
        end else if (rv_pipe_r[1]) begin
            frame_count_r <= frame_count_r + 16'h0001;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    assign frame_count = frame_count_r;
`endif

endmodule

// File: tb/tb_weight_bit_serializer.sv
// Directed bench for weight_bit_serializer: per-cycle output log, table of words with hand-derived bit streams.
module tb_weight_bit_serializer;
    localparam int LOG_N = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in_data = 16'h0000;
    logic        in_valid = 1'b0;
    logic        in_ready, enable_out, weight_bit, busy, result_valid;
`ifdef WSER_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    weight_bit_serializer dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .enable_out(enable_out), .weight_bit(weight_bit),
        .busy(busy),
`ifdef WSER_FRAME_COUNT_EN
        .frame_count(frame_count),
`endif
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit en_log[LOG_N], wb_log[LOG_N], rv_log[LOG_N], ir_log[LOG_N], bz_log[LOG_N];
    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            en_log[cyc] = enable_out;
            wb_log[cyc] = weight_bit;
            rv_log[cyc] = result_valid;
            ir_log[cyc] = in_ready;
            bz_log[cyc] = busy;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a word; acc returns the cycle index just after the accepting edge
    task automatic send(input logic [15:0] w, input bit hold, output int acc);
        bit r;
        in_data  = w;
        in_valid = 1'b1;
        acc = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) begin
                acc = cyc;
                if (!hold) in_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: word %h never accepted", w);
        in_valid = 1'b0;
    endtask

    // s is the phase-0 cycle; exp lists the 15 magnitude bits then the sign bit
    task automatic check_frame(input string nm, input int s, input logic [15:0] exp);
        logic [16:0] en_v, wb_v;
        logic [2:0]  rv_v;
        for (int i = 0; i < 17; i++) begin
            en_v[16-i] = en_log[s+i];
            wb_v[16-i] = wb_log[s+1+i];
        end
        rv_v = {rv_log[s+17], rv_log[s+18], rv_log[s+19]};
        chk({nm, "_enable"}, 32'(en_v), 32'h0001_FFFF);
        chk({nm, "_bits"}, 32'(wb_v), 32'({exp, 1'b0}));
        chk({nm, "_rvalid"}, 32'(rv_v), 32'h0000_0002);
    endtask

    typedef struct {
        logic [15:0] word;
        logic [15:0] stream;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int a, a0, a1, a2, ab, ac, s, s0, c0, run;
        logic any_en, any_rv, any_bz, all_ir, any_x;

        vecs[0] = '{16'h8400, 16'h0801};
        vecs[1] = '{16'h0001, 16'h0002};
        vecs[2] = '{16'h7FFF, 16'hFFFE};
        vecs[3] = '{16'h8000, 16'h0001};
        vecs[4] = '{16'h5555, 16'hAAAA};
        vecs[5] = '{16'h1234, 16'h2468};
        vecs[6] = '{16'hC00F, 16'h801F};

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_enable", 32'(enable_out), 32'h0);
        chk("rst_weight_bit", 32'(weight_bit), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_result_valid", 32'(result_valid), 32'h0);

        c0 = cyc;
        wait_cycles(21);
        any_en = 1'b0; any_rv = 1'b0; any_bz = 1'b0; all_ir = 1'b1;
        for (int i = 0; i < 20; i++) begin
            any_en |= en_log[c0+i];
            any_rv |= rv_log[c0+i];
            any_bz |= bz_log[c0+i];
            all_ir &= ir_log[c0+i];
        end
        chk("idle_quiet", 32'({any_en, any_rv, any_bz, all_ir}), 32'h1);

        // Isolated frames from the table
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].word, 1'b0, a);
            wait_cycles(22);
            check_frame($sformatf("vec%0d", i), a + 1, vecs[i].stream);
            chk($sformatf("vec%0d_busy", i), 32'({bz_log[a], bz_log[a+17], bz_log[a+18]}), 32'h6);
            chk($sformatf("vec%0d_ready", i), 32'({ir_log[a], ir_log[a+1]}), 32'h1);
            chk($sformatf("vec%0d_en_edges", i), 32'({en_log[a], en_log[a+18]}), 32'h0);
        end

        // Back-to-back stream with in_valid held high
        send(16'h0001, 1'b1, a0);
        send(16'h7FFF, 1'b1, a1);
        send(16'h8000, 1'b0, a2);
        s0 = a0 + 1;
        chk("b2b_accept1", 32'(a1 - a0), 32'd2);
        chk("b2b_accept2", 32'(a2 - s0), 32'd18);
        wait_cycles(60);
        run = 0;
        for (int i = 0; i < 60; i++) begin
            if (en_log[s0+i] && run == i) run++;
        end
        chk("b2b_enable_run", 32'(run), 32'd51);
        chk("b2b_enable_edges", 32'({en_log[s0-1], en_log[s0+51]}), 32'h0);
        check_frame("b2b0", s0, 16'h0002);
        check_frame("b2b1", s0 + 17, 16'hFFFE);
        check_frame("b2b2", s0 + 34, 16'h0001);

        // Backpressure: junk offered while the buffer is full must be ignored
        send(16'h0F0F, 1'b0, a);
        s = a + 1;
        send(16'h8001, 1'b0, ab);
        chk("bp_accept_b", 32'(ab - s), 32'd1);
        in_data  = 16'hFFFF;
        in_valid = 1'b1;
        wait_cycles(4);
        in_valid = 1'b0;
        any_x = 1'b0;
        for (int i = 1; i < 6; i++) any_x |= ir_log[s+i];
        chk("bp_ready_low", 32'(any_x), 32'h0);
        send(16'h4002, 1'b0, ac);
        chk("bp_accept_c", 32'(ac - s), 32'd18);
        wait_cycles(40);
        check_frame("bp_p", s, 16'h1E1E);
        check_frame("bp_b", s + 17, 16'h0003);
        check_frame("bp_c", s + 34, 16'h8004);

        // Reset at phase 7 of 0x5555, then a fresh word
        send(16'h5555, 1'b0, a);
        s = a + 1;
        for (int n = 0; n < 50 && cyc < s + 7; n++) wait_cycles(1);
        reset = 1'b0;
        wait_cycles(1);
        reset = 1'b1;
        wait_cycles(25);
        chk("mrst_before", 32'(en_log[s+7]), 32'h1);
        chk("mrst_after", 32'({en_log[s+8], wb_log[s+8], ir_log[s+8], bz_log[s+8]}), 32'h2);
        any_rv = 1'b0;
        for (int i = 8; i < 30; i++) any_rv |= rv_log[s+i];
        chk("mrst_no_rvalid", 32'(any_rv), 32'h0);
        send(16'h1234, 1'b0, a);
        wait_cycles(24);
        check_frame("mrst_fresh", a + 1, 16'h2468);
`ifdef WSER_FRAME_COUNT_EN
        chk("frame_count", 32'(frame_count), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
